ts_snapshot_arb: RTL and testbench

Shared timestamp source and snapshot arbiter for the capture path. It keeps a free-running seconds/nanoseconds clock using carry-based rollover, with no divider. It latches a timestamp in the exact cycle each capture port raises its request, then drains the latched snapshots one at a time through a valid/ready output in round-robin order. Software can load the clock to an absolute time.

---
 rtl/ts_pkg.sv | 21 ++
 rtl/ts_counter.sv | 56 +++++
 rtl/ts_snapshot_arb.sv | 130 +++++++++++++
 tb/tb_ts_snapshot_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and constants for the timestamp clock and snapshot arbiter.
// Optional set path is enabled with the TS_SET_EN macro.
package ts_pkg;

   localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

   typedef struct packed {
      logic [31:0] seconds;
      logic [31:0] nanoseconds;
   } ts_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   function automatic logic [31:0] ts_inc(input int freq_mhz);
      return 32'(1000 / freq_mhz);
   endfunction

endpackage

// File: rtl/ts_counter.sv
// Free-running seconds/nanoseconds clock with carry rollover and an absolute-time load.
// The load port is only active when TS_SET_EN is defined.
module ts_counter
   import ts_pkg::*;
#(
   parameter logic [31:0] INC = 32'd20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set_valid,
   input  logic [31:0] set_seconds,
   input  logic [31:0] set_nanoseconds,
   output logic        set_err,
   output logic [31:0] cur_seconds,
   output logic [31:0] cur_nanoseconds
);

   logic [32:0] ns_sum;
   logic        ns_wrap;
   logic [31:0] ns_next;
   logic        set_ok;
   logic        set_bad;

   assign ns_sum  = {1'b0, cur_nanoseconds} + {1'b0, INC};
   assign ns_wrap = (ns_sum >= {1'b0, NS_PER_SEC});
   assign ns_next = ns_wrap ? 32'(ns_sum - {1'b0, NS_PER_SEC}) : ns_sum[31:0];

`ifdef TS_SET_EN
   assign set_ok  = set_valid && (set_nanoseconds < NS_PER_SEC);
   assign set_bad = set_valid && !(set_nanoseconds < NS_PER_SEC);
`else
   logic unused_set;
   assign unused_set = ^{set_valid, set_seconds, set_nanoseconds};
   assign set_ok     = 1'b0;
   assign set_bad    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_seconds     <= '0;
         cur_nanoseconds <= '0;
         set_err         <= 1'b0;
      end else begin
         set_err <= set_bad;
         // A valid load replaces this cycle's increment outright.
         if (set_ok) begin
            cur_seconds     <= set_seconds;
            cur_nanoseconds <= set_nanoseconds;
         end else begin
            cur_nanoseconds <= ns_next;
            if (ns_wrap) cur_seconds <= cur_seconds + 32'd1;
         end
      end
   end

endmodule

// File: rtl/ts_snapshot_arb.sv
// Per-requester timestamp capture slots drained round-robin through one valid/ready port.
// Set path of the embedded clock is controlled by TS_SET_EN.
module ts_snapshot_arb
   import ts_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int FREQ    = 50
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       set_valid,
   input  logic [31:0]                set_seconds,
   input  logic [31:0]                set_nanoseconds,
   output logic                       set_err,
   output logic [31:0]                cur_seconds,
   output logic [31:0]                cur_nanoseconds,
   output logic                       snap_valid,
   input  logic                       snap_ready,
   output logic [$clog2(NUM_REQ)-1:0] snap_id,
   output logic [31:0]                snap_seconds,
   output logic [31:0]                snap_nanoseconds,
   output logic [NUM_REQ-1:0]         overrun,
   input  logic [NUM_REQ-1:0]         overrun_clr
);

   localparam int IDW = $clog2(NUM_REQ);

   ts_t                cur_ts;
   ts_t                slot [NUM_REQ];
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] drain_hit;
   logic [NUM_REQ-1:0] cap;
   logic [NUM_REQ-1:0] ovr_new;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     win;
   logic [IDW:0]       scan_sum;
   logic               any_pend;
   logic               load;
   arb_state_t         state, state_nxt;

   ts_counter #(.INC(ts_inc(FREQ))) u_counter (
      .clk             (clk),
      .reset           (reset),
      .set_valid       (set_valid),
      .set_seconds     (set_seconds),
      .set_nanoseconds (set_nanoseconds),
      .set_err         (set_err),
      .cur_seconds     (cur_seconds),
      .cur_nanoseconds (cur_nanoseconds)
   );

   assign cur_ts = {cur_seconds, cur_nanoseconds};

   // First pending slot at or above rr_ptr, wrapping.
   always_comb begin
      any_pend = 1'b0;
      win      = '0;
      scan_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_sum >= (IDW+1)'(NUM_REQ)) scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
         if (!any_pend && pending[scan_sum[IDW-1:0]]) begin
            any_pend = 1'b1;
            win      = scan_sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: if (any_pend) begin
            load      = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: if (snap_ready) begin
            if (any_pend) load = 1'b1;
            else          state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      drain_hit = '0;
      for (int i = 0; i < NUM_REQ; i++) drain_hit[i] = load && (win == IDW'(i));
   end

   // A slot being drained this cycle may be refilled without counting as a loss.
   assign cap     = req & (~pending | drain_hit);
   assign ovr_new = req & pending & ~drain_hit;

   assign snap_valid = (state == HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending          <= '0;
         overrun          <= '0;
         rr_ptr           <= '0;
         snap_id          <= '0;
         snap_seconds     <= '0;
         snap_nanoseconds <= '0;
         for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
      end else begin
         if (load) begin
            snap_id          <= win;
            snap_seconds     <= slot[win].seconds;
            snap_nanoseconds <= slot[win].nanoseconds;
            rr_ptr           <= (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cap[i]) begin
               slot[i]    <= cur_ts;
               pending[i] <= 1'b1;
            end else if (drain_hit[i]) begin
               pending[i] <= 1'b0;
            end
         end
         overrun <= (overrun & ~overrun_clr) | ovr_new;
      end
   end

endmodule

// File: tb/tb_ts_snapshot_arb.sv
// Bench for ts_snapshot_arb: directed table, hand sequences and a randomized run
// checked against a total-nanoseconds reference model.
module tb_ts_snapshot_arb;

   localparam int N = 4;
   localparam longint unsigned NSPS = 64'd1_000_000_000;
   localparam longint unsigned WRAP = 64'd4294967296 * NSPS;
   localparam longint unsigned INC  = 64'd20;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req = '0;
   logic          set_valid = 1'b0;
   logic [31:0]   set_seconds = '0;
   logic [31:0]   set_nanoseconds = '0;
   logic          set_err;
   logic [31:0]   cur_seconds, cur_nanoseconds;
   logic          snap_valid;
   logic          snap_ready = 1'b0;
   logic [1:0]    snap_id;
   logic [31:0]   snap_seconds, snap_nanoseconds;
   logic [N-1:0]  overrun;
   logic [N-1:0]  overrun_clr = '0;

   ts_snapshot_arb #(.NUM_REQ(N), .FREQ(50)) dut (
      .clk(clk), .reset(reset), .req(req),
      .set_valid(set_valid), .set_seconds(set_seconds), .set_nanoseconds(set_nanoseconds),
      .set_err(set_err), .cur_seconds(cur_seconds), .cur_nanoseconds(cur_nanoseconds),
      .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_id(snap_id),
      .snap_seconds(snap_seconds), .snap_nanoseconds(snap_nanoseconds),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: time kept as one total-nanoseconds number.
   longint unsigned m_time;
   longint unsigned m_slot [N];
   bit [N-1:0]      m_pend;
   bit [N-1:0]      m_ovr;
   int              m_rr;
   bit              m_v;
   int              m_id;
   longint unsigned m_t;
   bit              m_serr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_time = 0; m_pend = '0; m_ovr = '0; m_rr = 0;
      m_v = 0; m_id = 0; m_t = 0; m_serr = 0;
      for (int i = 0; i < N; i++) m_slot[i] = 0;
   endtask

   task automatic model_step(input bit [N-1:0] r, input bit rdy, input bit [N-1:0] clr,
                             input bit sv, input bit [31:0] ss, input bit [31:0] sns);
      int drained;
      bit [N-1:0] old_pend, ovr_new;
      longint unsigned now;
      now = m_time;
      old_pend = m_pend;
      ovr_new = '0;
      drained = -1;
      if (!m_v || rdy) begin
         for (int k = 0; k < N; k++)
            if (drained < 0 && old_pend[(m_rr + k) % N]) drained = (m_rr + k) % N;
         if (drained >= 0) begin
            m_v = 1; m_id = drained; m_t = m_slot[drained];
            m_pend[drained] = 0;
            m_rr = (drained + 1) % N;
         end else m_v = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (r[i]) begin
            if (!old_pend[i] || drained == i) begin
               m_slot[i] = now; m_pend[i] = 1;
            end else ovr_new[i] = 1;
         end
      end
      m_ovr = (m_ovr & ~clr) | ovr_new;
      m_serr = 0;
`ifdef TS_SET_EN
      if (sv && sns < NSPS) m_time = longint'(ss) * NSPS + longint'(sns);
      else begin
         m_serr = sv;
         m_time = m_time + INC;
      end
`else
      m_time = m_time + INC;
`endif
      if (m_time >= WRAP) m_time = m_time - WRAP;
   endtask

   task automatic compare_all();
      chk("cur_seconds", cur_seconds, 64'(m_time / NSPS));
      chk("cur_nanoseconds", cur_nanoseconds, 64'(m_time % NSPS));
      chk("snap_valid", snap_valid, m_v);
      if (m_v) begin
         chk("snap_id", snap_id, 64'(m_id));
         chk("snap_seconds", snap_seconds, 64'(m_t / NSPS));
         chk("snap_nanoseconds", snap_nanoseconds, 64'(m_t % NSPS));
      end
      chk("overrun", overrun, m_ovr);
      chk("set_err", set_err, m_serr);
   endtask

   task automatic cycle(input bit [N-1:0] r, input bit rdy, input bit [N-1:0] clr,
                        input bit sv = 0, input bit [31:0] ss = 0, input bit [31:0] sns = 0);
      req = r; snap_ready = rdy; overrun_clr = clr;
      set_valid = sv; set_seconds = ss; set_nanoseconds = sns;
      @(posedge clk); #1;
      model_step(r, rdy, clr, sv, ss, sns);
      compare_all();
      req = '0; overrun_clr = '0; set_valid = 0;
   endtask

   typedef struct {
      logic [N-1:0] req;
      bit           rdy;
      bit           exp_valid;
      int           exp_id;
   } vec_t;

   vec_t vecs [13];
   logic [63:0] saved;
   longint unsigned t_a, t_b;

   initial begin
      vecs[0]  = '{4'b0101, 1, 0, 0};
      vecs[1]  = '{4'b0000, 1, 1, 0};
      vecs[2]  = '{4'b0000, 1, 1, 2};
      vecs[3]  = '{4'b0000, 1, 0, 0};
      vecs[4]  = '{4'b1111, 1, 0, 0};
      vecs[5]  = '{4'b0000, 1, 1, 3};
      vecs[6]  = '{4'b0000, 1, 1, 0};
      vecs[7]  = '{4'b0000, 0, 1, 0};
      vecs[8]  = '{4'b0000, 0, 1, 0};
      vecs[9]  = '{4'b0000, 0, 1, 0};
      vecs[10] = '{4'b0000, 1, 1, 1};
      vecs[11] = '{4'b0000, 1, 1, 2};
      vecs[12] = '{4'b0000, 1, 0, 0};

      // Reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cur_s", cur_seconds, 0);
      chk("rst_cur_ns", cur_nanoseconds, 0);
      chk("rst_valid", snap_valid, 0);
      chk("rst_id", snap_id, 0);
      chk("rst_snap_s", snap_seconds, 0);
      chk("rst_snap_ns", snap_nanoseconds, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_set_err", set_err, 0);
      reset = 0;
      repeat (5) cycle('0, 1, '0);
      chk("free_run_ns", cur_nanoseconds, 100);
      chk("free_run_s", cur_seconds, 0);

      // Directed round-robin table
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].req, vecs[i].rdy, '0);
         chk("tbl_valid", snap_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) chk("tbl_id", snap_id, 64'(vecs[i].exp_id));
         if (i == 1 || i == 7) saved = {snap_seconds, snap_nanoseconds};
         if (i == 2) chk("same_ts_id0_id2", {snap_seconds, snap_nanoseconds}, saved);
         if (i == 9) chk("hold_stable", {snap_seconds, snap_nanoseconds}, saved);
      end

      // Overrun under backpressure
      cycle(4'b0001, 0, '0);
      cycle(4'b0000, 0, '0);
      t_a = m_time;
      cycle(4'b0010, 0, '0);
      cycle(4'b0010, 0, '0);
      chk("ovr_set", overrun, 4'b0010);
      cycle(4'b0000, 1, '0);
      chk("ovr_first_id", snap_id, 1);
      chk("ovr_first_ns", snap_nanoseconds, 64'(t_a % NSPS));
      cycle(4'b0000, 0, 4'b0010);
      chk("ovr_clr", overrun, 0);

      // Capture into a slot that is draining the same cycle
      t_a = m_time;
      cycle(4'b0100, 0, '0);
      t_b = m_time;
      cycle(4'b0100, 1, '0);
      chk("drain_cap_ovr", overrun, 0);
      chk("drain_cap_old_ns", snap_nanoseconds, 64'(t_a % NSPS));
      cycle(4'b0000, 1, '0);
      chk("drain_cap_id", snap_id, 2);
      chk("drain_cap_new_ns", snap_nanoseconds, 64'(t_b % NSPS));

      // Clear and new overrun in the same cycle
      cycle(4'b0100, 0, '0);
      cycle(4'b0100, 0, 4'b0100);
      chk("clr_vs_new_ovr", overrun, 4'b0100);
      cycle(4'b0000, 0, 4'b0100);
      chk("clr_after", overrun, 0);
      cycle(4'b0000, 1, '0);
      cycle(4'b0000, 1, '0);
      chk("drained_empty", snap_valid, 0);

      // Asynchronous reset with two slots pending
      cycle(4'b0011, 0, '0);
      reset = 1;
      #1;
      model_reset();
      chk("async_rst_valid", snap_valid, 0);
      chk("async_rst_ns", cur_nanoseconds, 0);
      @(posedge clk); #1;
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         cycle('0, 1, '0);
         chk("no_stale_snap", snap_valid, 0);
      end

`ifdef TS_SET_EN
      cycle('0, 1, '0, 1, 32'd5, 32'd999_999_980);
      chk("set_s", cur_seconds, 5);
      chk("set_ns", cur_nanoseconds, 999_999_980);
      cycle('0, 1, '0);
      chk("set_roll_s", cur_seconds, 6);
      chk("set_roll_ns", cur_nanoseconds, 0);
      cycle('0, 1, '0, 1, 32'd9, 32'd1_000_000_000);
      chk("set_bad_err", set_err, 1);
      chk("set_bad_ns", cur_nanoseconds, 20);
      cycle('0, 1, '0);
      chk("set_err_pulse", set_err, 0);
      cycle('0, 1, '0, 1, 32'hFFFF_FFFF, 32'd999_999_980);
      cycle('0, 1, '0);
      chk("sec_wrap_s", cur_seconds, 0);
      chk("sec_wrap_ns", cur_nanoseconds, 0);
`else
      cycle('0, 1, '0, 1, 32'd5, 32'd999_999_980);
      chk("set_ignored_err", set_err, 0);
      cycle('0, 1, '0, 1, 32'd9, 32'd1_000_000_000);
      chk("set_ignored_err2", set_err, 0);
`endif

      // Randomized run against the model
      for (int c = 0; c < 400; c++) begin
         bit [N-1:0] r, clr;
         bit sv;
         bit [31:0] sns;
         for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
         sv  = ($urandom_range(0, 19) == 0);
         sns = $urandom_range(0, 3) == 0 ? 32'd1_000_000_000 + $urandom_range(0, 1000)
                                         : $urandom_range(0, 999_999_999);
         cycle(r, 1'($urandom_range(0, 1)), clr, sv, $urandom, sns);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
